cajero_transaccion_ctrl: RTL



---
 rtl/cajero_pkg.sv | 27 ++
 rtl/cajero_temporizador.sv | 33 +++
 rtl/cajero_transaccion_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM transaction controller.
//   estado_t    : one-hot controller state encoding (5 bits)
//   IDX_*       : bit positions of the states that drive level outputs
//   TRANS_*     : tipo_trans codes (2'b11 is an invalid request)
//   es_espera() : true in the two states guarded by the inactivity timer
package cajero_pkg;

  typedef enum logic [4:0] {
    ST_IDLE         = 5'b00001,
    ST_ESPERA_PIN   = 5'b00010,
    ST_ESPERA_TRANS = 5'b00100,
    ST_EJECUTA      = 5'b01000,
    ST_BLOQUEADO    = 5'b10000
  } estado_t;

  localparam int unsigned IDX_IDLE      = 0;
  localparam int unsigned IDX_BLOQUEADO = 4;

  localparam logic [1:0] TRANS_DEPOSITO = 2'b00;
  localparam logic [1:0] TRANS_RETIRO   = 2'b01;
  localparam logic [1:0] TRANS_CONSULTA = 2'b10;

  function automatic logic es_espera(input estado_t s);
    return (s == ST_ESPERA_PIN) || (s == ST_ESPERA_TRANS);
  endfunction

endpackage

// File: rtl/cajero_temporizador.sv
// Inactivity timer for the waiting states.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clr        : force the count to zero (strobe consumed or state change)
//   en         : count one cycle of inactivity
//   expira     : high while enabled on the last tolerated idle cycle
//                (count == TIMEOUT-1)
module cajero_temporizador #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The controller leaves the waiting state when this fires, so the count
  // never runs past TIMEOUT-1.
  assign expira = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cajero_transaccion_ctrl.sv
// ATM transaction controller: card insertion, PIN check with attempt limit
// and lock, then one deposit / withdrawal / balance query per login.
// Optional build macro: LIMITE_DIARIO_EN enables the daily withdrawal cap.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tarjeta_recibida      level, card present
//   pin_stb, pin          entered PIN strobe and value
//   pin_correcto          stored PIN for the inserted card
//   trans_stb             transaction request strobe
//   tipo_trans, monto     request type and amount
//   balance_inicial       current balance, captured with trans_stb
//   nuevo_dia             strobe, clears the daily accumulator
//   balance_actualizado   result balance, held between balance_stb pulses
//   balance_stb           one-cycle result strobe
//   entregar_dinero       one-cycle dispense command
//   fondos_insuficientes  one-cycle reject, amount above balance
//   limite_excedido       one-cycle reject, daily cap (0 without the macro)
//   pin_incorrecto        one-cycle wrong-PIN pulse
//   bloqueo               level, card locked
//   ocupado               level, controller not idle
//
// Strobe semantics: each *_stb is a one-cycle valid with no ready; it is
// consumed only in the state that expects it and silently dropped elsewhere.
module cajero_transaccion_ctrl
  import cajero_pkg::*;
#(
  parameter int unsigned MONTO_W       = 32,
  parameter int unsigned BAL_W         = 64,
  parameter int unsigned PIN_W         = 16,
  parameter int unsigned MAX_INTENTOS  = 3,
  parameter int unsigned TIMEOUT       = 1000,
  parameter int unsigned LIMITE_DIARIO = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tarjeta_recibida,
  input  logic               pin_stb,
  input  logic [PIN_W-1:0]   pin,
  input  logic [PIN_W-1:0]   pin_correcto,
  input  logic               trans_stb,
  input  logic [1:0]         tipo_trans,
  input  logic [MONTO_W-1:0] monto,
  input  logic [BAL_W-1:0]   balance_inicial,
  input  logic               nuevo_dia,
  output logic [BAL_W-1:0]   balance_actualizado,
  output logic               balance_stb,
  output logic               entregar_dinero,
  output logic               fondos_insuficientes,
  output logic               limite_excedido,
  output logic               pin_incorrecto,
  output logic               bloqueo,
  output logic               ocupado
);

  localparam int unsigned IW = $clog2(MAX_INTENTOS + 1);

  estado_t          state_q, state_d;
  logic [IW-1:0]    intentos_q, intentos_d;
  logic [1:0]       tipo_q;
  logic [BAL_W-1:0] monto_q, bal_q;
  logic             cargar;
  logic [BAL_W:0]   suma;
  logic [BAL_W-1:0] bal_out_d;
  logic             stb_d, ent_d, fon_d, pininc_d;
  logic             cnt_clr, cnt_en, expira;

`ifdef LIMITE_DIARIO_EN
  localparam logic [BAL_W+1:0] LIMITE_EXT = (BAL_W+2)'(LIMITE_DIARIO);
  logic [BAL_W:0]   acum_q;
  logic [BAL_W:0]   acum_base;
  logic [BAL_W+1:0] acum_sum;
  logic             lim_d;

  // A new day coinciding with EJECUTA is cleared before the cap check.
  assign acum_base = nuevo_dia ? '0 : acum_q;
  assign acum_sum  = {1'b0, acum_base} + {2'b00, monto_q};
`endif

  assign cnt_en  = es_espera(state_q);
  assign ocupado = ~state_q[IDX_IDLE];
  assign bloqueo = state_q[IDX_BLOQUEADO];

  cajero_temporizador #(.TIMEOUT(TIMEOUT)) u_temporizador (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expira (expira)
  );

  always_comb begin
    state_d    = state_q;
    intentos_d = intentos_q;
    cargar     = 1'b0;
    bal_out_d  = balance_actualizado;
    stb_d      = 1'b0;
    ent_d      = 1'b0;
    fon_d      = 1'b0;
    pininc_d   = 1'b0;
    cnt_clr    = 1'b0;
    suma       = {1'b0, bal_q} + {1'b0, monto_q};
`ifdef LIMITE_DIARIO_EN
    lim_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        intentos_d = '0;
        cnt_clr    = 1'b1;
        if (tarjeta_recibida) state_d = ST_ESPERA_PIN;
      end

      ST_ESPERA_PIN: begin
        if (!tarjeta_recibida) begin
          state_d = ST_IDLE;
        end else if (pin_stb) begin
          cnt_clr = 1'b1;
          if (pin == pin_correcto) begin
            intentos_d = '0;
            state_d    = ST_ESPERA_TRANS;
          end else begin
            pininc_d   = 1'b1;
            intentos_d = intentos_q + IW'(1);
            if (intentos_d == IW'(MAX_INTENTOS)) state_d = ST_BLOQUEADO;
          end
        end else if (expira) begin
          state_d = ST_IDLE;
        end
      end

      ST_ESPERA_TRANS: begin
        if (!tarjeta_recibida) begin
          state_d = ST_IDLE;
        end else if (trans_stb) begin
          cnt_clr = 1'b1;
          cargar  = 1'b1;
          state_d = ST_EJECUTA;
        end else if (expira) begin
          state_d = ST_IDLE;
        end
      end

      ST_EJECUTA: begin
        state_d = ST_IDLE;
        case (tipo_q)
          TRANS_DEPOSITO: begin
            bal_out_d = suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
            stb_d     = 1'b1;
          end
          TRANS_RETIRO: begin
`ifdef LIMITE_DIARIO_EN
            if (acum_sum > LIMITE_EXT) lim_d = 1'b1;
            else
`endif
            if (monto_q > bal_q) begin
              fon_d = 1'b1;
            end else begin
              bal_out_d = bal_q - monto_q;
              stb_d     = 1'b1;
              ent_d     = 1'b1;
            end
          end
          TRANS_CONSULTA: begin
            bal_out_d = bal_q;
            stb_d     = 1'b1;
          end
          default: ;
        endcase
      end

      ST_BLOQUEADO: begin
        if (!tarjeta_recibida) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      intentos_q           <= '0;
      balance_actualizado  <= '0;
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      pin_incorrecto       <= 1'b0;
    end else begin
      state_q              <= state_d;
      intentos_q           <= intentos_d;
      balance_actualizado  <= bal_out_d;
      balance_stb          <= stb_d;
      entregar_dinero      <= ent_d;
      fondos_insuficientes <= fon_d;
      pin_incorrecto       <= pininc_d;
    end
  end

  // Request fields captured on the accepted trans_stb.
  always_ff @(posedge clk) begin
    if (reset) begin
      tipo_q  <= '0;
      monto_q <= '0;
      bal_q   <= '0;
    end else if (cargar) begin
      tipo_q  <= tipo_trans;
      monto_q <= BAL_W'(monto);
      bal_q   <= balance_inicial;
    end
  end

`ifdef LIMITE_DIARIO_EN
  // Only a dispensed withdrawal accumulates; it can never exceed the cap,
  // so the stored value fits in BAL_W+1 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      acum_q          <= '0;
      limite_excedido <= 1'b0;
    end else begin
      limite_excedido <= lim_d;
      if (ent_d)          acum_q <= acum_sum[BAL_W:0];
      else if (nuevo_dia) acum_q <= '0;
    end
  end
`else
  assign limite_excedido = 1'b0;
  logic unused_cfg;
  assign unused_cfg = &{1'b0, nuevo_dia, (LIMITE_DIARIO != 0)};
`endif

endmodule
